// File: rtl/mul_div_pkg.sv
// Shared definitions for the RV32M multiply/divide controller and the iterative unit it drives.
package mul_div_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  typedef enum logic {
    SEL_LOW  = 1'b0,
    SEL_HIGH = 1'b1
  } res_sel_e;

  // The unit returns quotient in low and remainder in high, product split across both.
  function automatic res_sel_e res_sel(input logic [2:0] funct3);
    res_sel_e sel;
    sel = SEL_LOW;
    case (funct3)
      F3_MULH, F3_MULHSU, F3_MULHU, F3_REM, F3_REMU: sel = SEL_HIGH;
      default:                                       sel = SEL_LOW;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mul_div_result_sel.sv
// Combinational funct3 decode: picks the result half and derives operand signedness.
module mul_div_result_sel
  import mul_div_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] high_i,
  input  logic [31:0] low_i,
  output logic [31:0] result_o,
  output logic        rs1_signed_o,
  output logic        rs2_signed_o
);

  always_comb begin
    result_o     = (res_sel(funct3_i) == SEL_HIGH) ? high_i : low_i;
    rs1_signed_o = !((funct3_i == F3_MULHU) || (funct3_i == F3_DIVU) || (funct3_i == F3_REMU));
    rs2_signed_o = (funct3_i == F3_MUL) || (funct3_i == F3_MULH) ||
                   (funct3_i == F3_DIV) || (funct3_i == F3_REM);
  end

endmodule

// File: rtl/mul_div_ctrl.sv
// EX-stage initiator for the multi-cycle mul/div unit: request sequencing, flush abort, result select.
// Optional result reuse of the last completed operation is enabled by defining MUL_DIV_REUSE_EN.
module mul_div_ctrl
  import mul_div_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inst_valid_i,
  input  logic [6:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        mul_div_req_o,
  output logic [2:0]  m_d_op_o,
  output logic [6:0]  op_o,
  output logic [31:0] rs1_o,
  output logic [31:0] rs2_o,
  output logic        rs1_signed_o,
  output logic        rs2_signed_o,
  input  logic [31:0] high_i,
  input  logic [31:0] low_i,
  input  logic        ready_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o
);

  md_state_e   state_q, state_d;
  logic        req_q;
  logic [2:0]  m_d_op_q;
  logic [6:0]  op_q;
  logic [31:0] rs1_q, rs2_q;
  logic        rs1_signed_q, rs2_signed_q;
  logic [4:0]  rd_q;
  logic [31:0] wb_data_q, wb_data_d;

  logic        launch, complete, abort, hit;
  logic [31:0] cache_high, cache_low;
  logic [31:0] launch_res, done_res;
  logic        launch_rs1_signed, launch_rs2_signed;
  logic        done_rs1_signed, done_rs2_signed;

  // Launch-side decode feeds both the signedness latch and a reuse hit's result.
  mul_div_result_sel u_launch_sel (
    .funct3_i     (funct3_i),
    .high_i       (cache_high),
    .low_i        (cache_low),
    .result_o     (launch_res),
    .rs1_signed_o (launch_rs1_signed),
    .rs2_signed_o (launch_rs2_signed)
  );

  mul_div_result_sel u_done_sel (
    .funct3_i     (m_d_op_q),
    .high_i       (high_i),
    .low_i        (low_i),
    .result_o     (done_res),
    .rs1_signed_o (done_rs1_signed),
    .rs2_signed_o (done_rs2_signed)
  );

`ifdef MUL_DIV_REUSE_EN
  logic        cache_vld_q;
  logic [31:0] cache_rs1_q, cache_rs2_q, cache_high_q, cache_low_q;
  logic [2:0]  cache_f3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_vld_q  <= 1'b0;
      cache_rs1_q  <= '0;
      cache_rs2_q  <= '0;
      cache_f3_q   <= '0;
      cache_high_q <= '0;
      cache_low_q  <= '0;
    end else if (complete) begin
      cache_vld_q  <= 1'b1;
      cache_rs1_q  <= rs1_q;
      cache_rs2_q  <= rs2_q;
      cache_f3_q   <= m_d_op_q;
      cache_high_q <= high_i;
      cache_low_q  <= low_i;
    end else if (abort) begin
      cache_vld_q  <= 1'b0;
    end
  end

  // DIV/REM (and DIVU/REMU) share one unit run, so divides only need matching signedness.
  always_comb begin
    hit = cache_vld_q && (rs1_data_i == cache_rs1_q) && (rs2_data_i == cache_rs2_q) &&
          (( funct3_i[2] &&  cache_f3_q[2] && (funct3_i[0] == cache_f3_q[0])) ||
           (!funct3_i[2] && !cache_f3_q[2] && (funct3_i == cache_f3_q)));
  end

  assign cache_high = cache_high_q;
  assign cache_low  = cache_low_q;
`else
  assign hit        = 1'b0;
  assign cache_high = '0;
  assign cache_low  = '0;
`endif

  always_comb begin
    launch    = (state_q == ST_IDLE) && inst_valid_i && (op_i == INST_TYPE_R_M) && !flush_i;
    complete  = (state_q == ST_BUSY) && ready_i && !flush_i;
    abort     = (state_q == ST_BUSY) && flush_i;
    state_d   = state_q;
    wb_data_d = wb_data_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = hit ? ST_DONE : ST_BUSY;
      ST_BUSY: begin
        if (flush_i)      state_d = ST_IDLE;
        else if (ready_i) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (complete)          wb_data_d = done_res;
    else if (launch && hit) wb_data_d = launch_res;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= (state_d == ST_BUSY);
      wb_data_q <= wb_data_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_d_op_q     <= '0;
      op_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs1_signed_q <= 1'b0;
      rs2_signed_q <= 1'b0;
      rd_q         <= '0;
    end else if (launch) begin
      m_d_op_q     <= funct3_i;
      op_q         <= op_i;
      rs1_q        <= rs1_data_i;
      rs2_q        <= rs2_data_i;
      rs1_signed_q <= launch_rs1_signed;
      rs2_signed_q <= launch_rs2_signed;
      rd_q         <= rd_addr_i;
    end
  end

  // Reset gates the combinational launch term so every output reads 0 while reset is held.
  assign stall_o       = rst_ni && (launch || (state_q == ST_BUSY));
  assign mul_div_req_o = req_q;
  assign m_d_op_o      = m_d_op_q;
  assign op_o          = op_q;
  assign rs1_o         = rs1_q;
  assign rs2_o         = rs2_q;
  assign rs1_signed_o  = rs1_signed_q;
  assign rs2_signed_o  = rs2_signed_q;
  assign wb_valid_o    = (state_q == ST_DONE);
  assign wb_rd_o       = rd_q;
  assign wb_data_o     = wb_data_q;

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Directed bench for mul_div_ctrl; acts as the mul/div unit by driving hand-computed high/low/ready.
// Reuse-path checks run only when MUL_DIV_REUSE_EN is defined.
module tb_mul_div_ctrl;
  import mul_div_pkg::*;

  logic        clk_i, rst_ni;
  logic        inst_valid_i, flush_i, ready_i;
  logic [6:0]  op_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i, rs2_data_i, high_i, low_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o, mul_div_req_o, rs1_signed_o, rs2_signed_o, wb_valid_o;
  logic [2:0]  m_d_op_o;
  logic [6:0]  op_o;
  logic [31:0] rs1_o, rs2_o, wb_data_o;
  logic [4:0]  wb_rd_o;

  int nAsserts = 0;
  int nFails   = 0;

  mul_div_ctrl dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .inst_valid_i  (inst_valid_i),
    .op_i          (op_i),
    .funct3_i      (funct3_i),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .rd_addr_i     (rd_addr_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .mul_div_req_o (mul_div_req_o),
    .m_d_op_o      (m_d_op_o),
    .op_o          (op_o),
    .rs1_o         (rs1_o),
    .rs2_o         (rs2_o),
    .rs1_signed_o  (rs1_signed_o),
    .rs2_signed_o  (rs2_signed_o),
    .high_i        (high_i),
    .low_i         (low_i),
    .ready_i       (ready_i),
    .wb_valid_o    (wb_valid_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    inst_valid_i = 1'b1;
    op_i         = op;
    funct3_i     = f3;
    rs1_data_i   = a;
    rs2_data_i   = b;
    rd_addr_i    = rd;
  endtask

  // Full request/response transaction; lat is the cycle (after launch) in which ready_i pulses.
  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [31:0] expData, input logic expS1, input logic expS2);
    applyStimulus(INST_TYPE_R_M, f3, a, b, rd);
    #1;
    checkOutput({tag, " C0 stall"}, 32'(stall_o), 32'd1);
    checkOutput({tag, " C0 req"}, 32'(mul_div_req_o), 32'd0);
    for (int k = 1; k <= lat; k++) begin
      step();
      high_i  = hi;
      low_i   = lo;
      ready_i = (k == lat);
      #1;
      checkOutput($sformatf("%s C%0d stall", tag, k), 32'(stall_o), 32'd1);
      checkOutput($sformatf("%s C%0d req", tag, k), 32'(mul_div_req_o), 32'd1);
      checkOutput($sformatf("%s C%0d wb_valid", tag, k), 32'(wb_valid_o), 32'd0);
      if (k == 1) begin
        checkOutput({tag, " m_d_op"}, 32'(m_d_op_o), 32'(f3));
        checkOutput({tag, " op"}, 32'(op_o), 32'(INST_TYPE_R_M));
        checkOutput({tag, " rs1"}, rs1_o, a);
        checkOutput({tag, " rs2"}, rs2_o, b);
        checkOutput({tag, " rs1_signed"}, 32'(rs1_signed_o), 32'(expS1));
        checkOutput({tag, " rs2_signed"}, 32'(rs2_signed_o), 32'(expS2));
      end
    end
    step();
    ready_i = 1'b0;
    #1;
    checkOutput({tag, " done wb_valid"}, 32'(wb_valid_o), 32'd1);
    checkOutput({tag, " done wb_data"}, wb_data_o, expData);
    checkOutput({tag, " done wb_rd"}, 32'(wb_rd_o), 32'(rd));
    checkOutput({tag, " done stall"}, 32'(stall_o), 32'd0);
    checkOutput({tag, " done req"}, 32'(mul_div_req_o), 32'd0);
    step();
    inst_valid_i = 1'b0;
    #1;
    checkOutput({tag, " idle wb_valid"}, 32'(wb_valid_o), 32'd0);
    checkOutput({tag, " idle stall"}, 32'(stall_o), 32'd0);
    checkOutput({tag, " idle req"}, 32'(mul_div_req_o), 32'd0);
  endtask

  initial begin
    rst_ni       = 1'b0;
    inst_valid_i = 1'b0;
    flush_i      = 1'b0;
    ready_i      = 1'b0;
    op_i         = '0;
    funct3_i     = '0;
    rs1_data_i   = '0;
    rs2_data_i   = '0;
    rd_addr_i    = '0;
    high_i       = '0;
    low_i        = '0;

    #3;
    checkOutput("reset stall", 32'(stall_o), 32'd0);
    checkOutput("reset req", 32'(mul_div_req_o), 32'd0);
    checkOutput("reset wb_valid", 32'(wb_valid_o), 32'd0);
    checkOutput("reset wb_data", wb_data_o, 32'd0);
    checkOutput("reset rs1", rs1_o, 32'd0);
    checkOutput("reset rs1_signed", 32'(rs1_signed_o), 32'd0);
    step();
    step();
    rst_ni = 1'b1;

    // Non-M opcode must not launch.
    applyStimulus(7'b0010011, F3_MUL, 32'd5, 32'd6, 5'd1);
    #1;
    checkOutput("non-M stall", 32'(stall_o), 32'd0);
    step();
    checkOutput("non-M req", 32'(mul_div_req_o), 32'd0);
    inst_valid_i = 1'b0;

    runOp("MUL 7*-3", F3_MUL, 32'h00000007, 32'hFFFFFFFD, 5'd3, 33,
          32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFEB, 1'b1, 1'b1);
    runOp("DIVU 100/0", F3_DIVU, 32'd100, 32'd0, 5'd4, 2,
          32'd100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    runOp("MULHU", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 33,
          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
    runOp("REMU 100/0", F3_REMU, 32'd100, 32'd0, 5'd0, 2,
          32'd100, 32'hFFFFFFFF, 32'd100, 1'b0, 1'b0);
    runOp("REM -7/2", F3_REM, 32'hFFFFFFF9, 32'd2, 5'd6, 33,
          32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1, 1'b1);

    // Flush a DIV in its tenth cycle; ready arriving later must be ignored.
    applyStimulus(INST_TYPE_R_M, F3_DIV, 32'd1000, 32'd7, 5'd7);
    #1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 10) flush_i = 1'b1;
      #1;
      checkOutput($sformatf("flush C%0d req", k), 32'(mul_div_req_o), 32'd1);
    end
    checkOutput("flush C10 stall", 32'(stall_o), 32'd1);
    step();
    flush_i      = 1'b0;
    inst_valid_i = 1'b0;
    #1;
    checkOutput("flush C11 req", 32'(mul_div_req_o), 32'd0);
    checkOutput("flush C11 stall", 32'(stall_o), 32'd0);
    checkOutput("flush C11 wb_valid", 32'(wb_valid_o), 32'd0);
    runOp("MUL 3*4", F3_MUL, 32'd3, 32'd4, 5'd8, 33,
          32'd0, 32'd12, 32'd12, 1'b1, 1'b1);

`ifdef MUL_DIV_REUSE_EN
    runOp("DIV 20/6", F3_DIV, 32'd20, 32'd6, 5'd9, 33,
          32'd2, 32'd3, 32'd3, 1'b1, 1'b1);
    applyStimulus(INST_TYPE_R_M, F3_REM, 32'd20, 32'd6, 5'd10);
    #1;
    checkOutput("reuse C0 stall", 32'(stall_o), 32'd1);
    checkOutput("reuse C0 req", 32'(mul_div_req_o), 32'd0);
    step();
    checkOutput("reuse C1 wb_valid", 32'(wb_valid_o), 32'd1);
    checkOutput("reuse C1 wb_data", wb_data_o, 32'd2);
    checkOutput("reuse C1 wb_rd", 32'(wb_rd_o), 32'd10);
    checkOutput("reuse C1 req", 32'(mul_div_req_o), 32'd0);
    checkOutput("reuse C1 stall", 32'(stall_o), 32'd0);
    step();
    inst_valid_i = 1'b0;
    #1;
    checkOutput("reuse idle wb_valid", 32'(wb_valid_o), 32'd0);
    runOp("REMU 20/6 miss", F3_REMU, 32'd20, 32'd6, 5'd11, 33,
          32'd2, 32'd3, 32'd2, 1'b0, 1'b0);
`else
    runOp("DIV 20/6", F3_DIV, 32'd20, 32'd6, 5'd9, 33,
          32'd2, 32'd3, 32'd3, 1'b1, 1'b1);
    runOp("REM 20/6", F3_REM, 32'd20, 32'd6, 5'd10, 33,
          32'd2, 32'd3, 32'd2, 1'b1, 1'b1);
`endif

    // Reset in the fifteenth cycle of a MUL clears everything immediately.
    applyStimulus(INST_TYPE_R_M, F3_MUL, 32'd5, 32'd6, 5'd12);
    #1;
    for (int k = 1; k <= 15; k++) step();
    checkOutput("rst C15 req before", 32'(mul_div_req_o), 32'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst req", 32'(mul_div_req_o), 32'd0);
    checkOutput("rst stall", 32'(stall_o), 32'd0);
    checkOutput("rst wb_valid", 32'(wb_valid_o), 32'd0);
    checkOutput("rst wb_data", wb_data_o, 32'd0);
    checkOutput("rst wb_rd", 32'(wb_rd_o), 32'd0);
    checkOutput("rst m_d_op", 32'(m_d_op_o), 32'd0);
    checkOutput("rst op", 32'(op_o), 32'd0);
    checkOutput("rst rs1", rs1_o, 32'd0);
    checkOutput("rst rs2", rs2_o, 32'd0);
    checkOutput("rst rs1_signed", 32'(rs1_signed_o), 32'd0);
    inst_valid_i = 1'b0;
    step();
    rst_ni = 1'b1;
    runOp("MUL 16*16 after rst", F3_MUL, 32'd16, 32'd16, 5'd13, 33,
          32'd0, 32'h100, 32'h100, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/mul_div_ctrl.md
# mul_div_ctrl

Initiator side of the EX-stage multiply/divide handshake. Accepts a decoded RV32M instruction from the EX stage, drives the multi-cycle mul/div unit's request interface, stalls the pipeline while it iterates, and presents the selected 32-bit result to writeback. The unit it drives clears its internal state whenever its request is low, so this block owns request sequencing, abort on flush, and result selection.

## Interface
- No parameters; widths fixed at RV32.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- inst_valid_i  in  1  EX stage holds a valid instruction
- op_i  in  7  opcode; only INST_TYPE_R_M launches
- funct3_i  in  3  M-extension function code
- rs1_data_i, rs2_data_i  in  32  operand values
- rd_addr_i  in  5  destination register
- flush_i  in  1  pipeline flush; aborts an in-flight operation
- stall_o  out  1  hold IF/ID/EX
- mul_div_req_o  out  1  request to unit (registered)
- m_d_op_o  out  3  latched funct3
- op_o  out  7  latched opcode
- rs1_o, rs2_o  out  32  latched operands
- rs1_signed_o, rs2_signed_o  out  1  operand signedness flags
- high_i, low_i  in  32  unit result halves
- ready_i  in  1  unit result valid
- wb_valid_o  out  1  one-cycle writeback strobe
- wb_rd_o  out  5  writeback register
- wb_data_o  out  32  writeback data

## Operation
- Launch: state IDLE && inst_valid_i && op_i==INST_TYPE_R_M && !flush_i. Latch funct3, opcode, rs1/rs2, rd.
- FSM IDLE -> BUSY on launch; BUSY -> DONE on ready_i && !flush_i; BUSY -> IDLE on flush_i (flush wins over ready_i); DONE -> IDLE unconditionally; DONE never relaunches.
- mul_div_req_o = 1 exactly while in BUSY; 0 in IDLE/DONE, guaranteeing the unit sees at least one edge with request low between operations.
- stall_o = launch (combinational, IDLE) || state==BUSY. 0 in DONE so the instruction retires.
- Signedness: rs1_signed_o=0 for funct3 011,101,111; rs2_signed_o=1 for 000,001,100,110.
- Result select on ready_i: 000 MUL->low_i; 001/010/011 MULH*->high_i; 100/101 DIV/DIVU->low_i; 110/111 REM/REMU->high_i. Registered into wb_data_o.
- wb_valid_o=1 only in DONE; wb_rd_o holds latched rd. rd==0 still strobes; regfile discards.
- Divide-by-zero and zero-operand results are taken as delivered by the unit (quotient all-ones, remainder rs1).

## Timing
- Reset: state IDLE; mul_div_req_o, wb_valid_o, stall_o 0; all latched/data outputs 0.
- Launch cycle = C0. Zero-operand: ready_i in C2, wb_valid_o in C3, stall C0..C2. Normal: ready_i in C33, wb_valid_o in C34, stall C0..C33.
- Flush in BUSY: req low from next cycle, no wb_valid_o, stall drops next cycle; a new launch is legal in that IDLE cycle.
- Reset mid-operation: immediate return to IDLE, req drops asynchronously.

## Configuration
- MUL_DIV_REUSE_EN defined: keep last completed {rs1, rs2, funct3, high, low} plus valid bit. Hit when valid, operands equal, and both divides with equal funct3[0] or both multiplies with equal funct3. Hit: IDLE -> DONE directly, no request, stall only in C0, wb_valid_o in C1. Valid cleared on reset and flush abort.
- Undefined: no storage; every instruction issues a request.

## Structure
- mul_div_pkg: INST_TYPE_R_M, funct3 codes, state enum, result-select constants; shared with the unit.
- One sub-module: mul_div_result_sel (combinational funct3 -> high/low select, signedness flags).

## Test plan
- MUL 7*-3 (0x00000007, 0xFFFFFFFD) -> wb_data_o 0xFFFFFFEB, wb_valid_o at C34, stall_o high C0..C33.
- DIVU 100/0 -> wb_data_o 0xFFFFFFFF at C3; REMU 100/0 -> 100.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; REM -7/2 -> 0xFFFFFFFF.
- Flush at C10 of DIV -> no wb_valid_o, req low C11, next MUL 3*4 -> 12 correct.
- With MUL_DIV_REUSE_EN: DIV 20/6 then REM 20/6 -> 3, then 2 at C1 with no request; REMU 20/6 after DIV misses.
- rst_ni low at C15 -> all outputs 0 immediately, following instruction completes normally.
